// File: rtl/ram2_pkg.sv
// -----------------------------------------------------------------------------
// ram2_pkg
// Shared definitions for the ram2 access arbiter: RAM geometry, the arbiter
// FSM state type and the round-robin index arithmetic used by the picker and
// by the pointer update.
// -----------------------------------------------------------------------------
package ram2_pkg;

   localparam int RAM_ADDR_W = 5;
   localparam int RAM_DATA_W = 32;

   typedef enum logic {
      IDLE   = 1'b0,
      ACCESS = 1'b1
   } state_t;

   // (base + off) mod n, valid for base < n and off < n.
   function automatic int rr_index(input int base, input int off, input int n);
      int j;
      j = base + off;
      return (j >= n) ? j - n : j;
   endfunction

   // Pointer value after granting idx: the requester just above it.
   function automatic int rr_next(input int idx, input int n);
      return rr_index(idx, 1, n);
   endfunction

endpackage

// File: rtl/ram2_port_arbiter_rr_pick.sv
// -----------------------------------------------------------------------------
// rr_pick
// Combinational round-robin priority picker. Returns the first set request at
// or after rr_ptr, wrapping from NREQ-1 to 0.
//   req    in  NREQ   request vector
//   rr_ptr in  IDX_W  highest-priority index this round
//   winner out IDX_W  index of the chosen requester (0 when any=0)
//   any    out 1      at least one request is set
// -----------------------------------------------------------------------------
module rr_pick
   import ram2_pkg::*;
#(
   parameter int NREQ  = 2,
   parameter int IDX_W = 1
) (
   input  logic [NREQ-1:0]  req,
   input  logic [IDX_W-1:0] rr_ptr,
   output logic [IDX_W-1:0] winner,
   output logic             any
);

   // NOTE: every output of a combinational block gets a default before any
   // condition; a path that leaves one unassigned would infer a latch.
   always_comb begin
      winner = '0;
      any    = 1'b0;
      // Scan from rr_ptr upward; only the first hit is taken.
      for (int k = 0; k < NREQ; k++) begin
         if (!any && req[rr_index(int'(rr_ptr), k, NREQ)]) begin
            any    = 1'b1;
            winner = IDX_W'(rr_index(int'(rr_ptr), k, NREQ));
         end
      end
   end

endmodule

// File: rtl/ram2_port_arbiter.sv
// -----------------------------------------------------------------------------
// ram2_port_arbiter
// Shares one ram2 (32 x 32, bidirectional data) among NREQ requesters. One
// request is latched per transaction in IDLE; the following ACCESS cycle drives
// the RAM pins from registered state only, then the FSM returns to IDLE, which
// doubles as the bus-turnaround cycle.
//   clk, rst_n  clock, asynchronous active-low reset
//   req/we      per-requester request and command (1 = write), held until gnt
//   addr/wdata  per-requester address/write data, packed i*W +: W
//   gnt         one-hot pulse during the access cycle: command latched
//   rvalid      one-hot pulse: rdata holds that requester's read data
//   rdata       last captured read data
//   ram_ena/ram_wena/ram_addr/ram_data   ram2 pins; ram_data driven only on
//                                        a write access, else released
// -----------------------------------------------------------------------------
module ram2_port_arbiter
   import ram2_pkg::*;
#(
   parameter int NREQ   = 2,
   parameter int ADDR_W = RAM_ADDR_W,
   parameter int DATA_W = RAM_DATA_W
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic [NREQ-1:0]        req,
   input  logic [NREQ-1:0]        we,
   input  logic [NREQ*ADDR_W-1:0] addr,
   input  logic [NREQ*DATA_W-1:0] wdata,
   output logic [NREQ-1:0]        gnt,
   output logic [NREQ-1:0]        rvalid,
   output logic [DATA_W-1:0]      rdata,
   output logic                   ram_ena,
   output logic                   ram_wena,
   output logic [ADDR_W-1:0]      ram_addr,
   inout  logic [DATA_W-1:0]      ram_data
);

   localparam int IDX_W = (NREQ > 1) ? $clog2(NREQ) : 1;

   state_t              r_state;
   state_t              w_next_state;
   logic [IDX_W-1:0]    r_rr_ptr;
   logic [IDX_W-1:0]    r_cmd_idx;
   logic                r_cmd_we;
   logic [ADDR_W-1:0]   r_cmd_addr;
   logic [DATA_W-1:0]   r_cmd_wdata;
   logic [NREQ-1:0]     r_rvalid;
   logic [DATA_W-1:0]   r_rdata;

   logic [IDX_W-1:0]    w_win;
   logic                w_any;
   logic                w_load;
   logic                w_access;
   logic                w_drive;
   logic [NREQ-1:0]     w_gnt;

   rr_pick #(
      .NREQ  (NREQ),
      .IDX_W (IDX_W)
   ) u_rr_pick (
      .req    (req),
      .rr_ptr (r_rr_ptr),
      .winner (w_win),
      .any    (w_any)
   );

   // NOTE: state registers use non-blocking assignments so every flop samples
   // the pre-edge value of its inputs regardless of block ordering.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_state <= IDLE;
      else        r_state <= w_next_state;
   end

   // Next state and pin decode; everything here depends on registered state,
   // so req never reaches the RAM pins combinationally.
   always_comb begin
      w_next_state = r_state;
      w_load       = 1'b0;
      w_access     = 1'b0;
      w_gnt        = '0;
      case (r_state)
         IDLE: begin
            if (w_any) begin
               w_next_state = ACCESS;
               w_load       = 1'b1;
            end
         end
         ACCESS: begin
            w_access         = 1'b1;
            w_gnt[r_cmd_idx] = 1'b1;
            w_next_state     = IDLE;
         end
         default: w_next_state = IDLE;
      endcase
   end

   // NOTE: the command registers are reset even though they are only consumed
   // in ACCESS; they are a handful of flops and it keeps the pins and rvalid
   // decode free of unknowns straight out of reset.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_rr_ptr    <= '0;
         r_cmd_idx   <= '0;
         r_cmd_we    <= 1'b0;
         r_cmd_addr  <= '0;
         r_cmd_wdata <= '0;
      end else if (w_load) begin
         r_cmd_idx   <= w_win;
         r_cmd_we    <= we[w_win];
         r_cmd_addr  <= addr[w_win*ADDR_W +: ADDR_W];
         r_cmd_wdata <= wdata[w_win*DATA_W +: DATA_W];
         r_rr_ptr    <= IDX_W'(rr_next(int'(w_win), NREQ));
      end
   end

   // ram2 drives ram_data combinationally during a read access; capture it at
   // the edge that closes the access.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_rvalid <= '0;
         r_rdata  <= '0;
      end else begin
         r_rvalid <= '0;
         if (w_access && !r_cmd_we) begin
            r_rvalid[r_cmd_idx] <= 1'b1;
            r_rdata             <= ram_data;
         end
      end
   end

   assign w_drive  = w_access && r_cmd_we;
   assign ram_ena  = w_access;
   assign ram_wena = w_drive;
   assign ram_addr = w_access ? r_cmd_addr : '0;
   assign ram_data = w_drive ? r_cmd_wdata : {DATA_W{1'bz}};

   assign gnt    = w_gnt;
   assign rvalid = r_rvalid;
   assign rdata  = r_rdata;

endmodule

// File: tb/tb_ram2_port_arbiter.sv
// -----------------------------------------------------------------------------
// tb_ram2_port_arbiter
// Bench for ram2_port_arbiter with a behavioural ram2 on the shared bus.
// Requesters are fed from per-requester command queues; at each grant the
// bench updates its shadow memory (writes) or pushes the expected read data
// and due cycle (reads); rvalid pops and compares.
// -----------------------------------------------------------------------------
module tb_ram2_port_arbiter;
   import ram2_pkg::*;

   localparam int NREQ = 2;
   localparam int AW   = RAM_ADDR_W;
   localparam int DW   = RAM_DATA_W;

   typedef struct {
      logic          we;
      logic [AW-1:0] a;
      logic [DW-1:0] d;
   } cmd_t;

   typedef struct {
      logic [DW-1:0] d;
      int            due;
   } rd_t;

   logic                clk   = 1'b0;
   logic                rst_n = 1'b0;
   logic [NREQ-1:0]     req   = '0;
   logic [NREQ-1:0]     we    = '0;
   logic [NREQ*AW-1:0]  addr  = '0;
   logic [NREQ*DW-1:0]  wdata = '0;
   logic [NREQ-1:0]     gnt;
   logic [NREQ-1:0]     rvalid;
   logic [DW-1:0]       rdata;
   logic                ram_ena;
   logic                ram_wena;
   logic [AW-1:0]       ram_addr;
   wire  [DW-1:0]       ram_data;

   logic [DW-1:0] mem    [32];
   logic [DW-1:0] shadow [32];

   cmd_t cmdq [NREQ][$];
   rd_t  rdq  [NREQ][$];
   int   exp_gnt[$];
   int   obs_cyc[$];
   int   first_sample [NREQ];

   int   cyc      = 0;
   int   n_checks = 0;
   int   n_errors = 0;
   bit   auto_drv = 1'b1;
   logic prev_ena = 1'b0;

   ram2_port_arbiter #(
      .NREQ   (NREQ),
      .ADDR_W (AW),
      .DATA_W (DW)
   ) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .req      (req),
      .we       (we),
      .addr     (addr),
      .wdata    (wdata),
      .gnt      (gnt),
      .rvalid   (rvalid),
      .rdata    (rdata),
      .ram_ena  (ram_ena),
      .ram_wena (ram_wena),
      .ram_addr (ram_addr),
      .ram_data (ram_data)
   );

   // Behavioural ram2: combinational read drive, write on the rising edge.
   assign ram_data = (ram_ena && !ram_wena) ? mem[ram_addr] : {DW{1'bz}};

   always #5 clk = ~clk;

   always @(posedge clk) begin
      cyc <= cyc + 1;
      if (cyc == 0) begin
         for (int i = 0; i < 32; i++) mem[i] <= 32'h1000_0000 + 32'(i);
      end else if (ram_ena && ram_wena) begin
         mem[ram_addr] <= ram_data;
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h, want %h (cycle %0d)", tag, act, exp, cyc);
      end
   endtask

   task automatic push_cmd(input int i, input logic w, input logic [AW-1:0] a, input logic [DW-1:0] d);
      cmd_t c;
      c.we = w;
      c.a  = a;
      c.d  = d;
      cmdq[i].push_back(c);
   endtask

   // Runs at every falling edge: scoreboard, grant checks, requester drive.
   task automatic monitor_step();
      logic [NREQ-1:0] g;
      cmd_t            c;
      rd_t             r;
      int              idx;
      g = gnt;
      if (rst_n) begin
         if (ram_ena) check("turnaround", {31'b0, prev_ena}, 32'd0);
         if (ram_ena && !ram_wena) check("rd_bus", ram_data, mem[ram_addr]);
         for (int i = 0; i < NREQ; i++) begin
            if (rvalid[i]) begin
               if (rdq[i].size() == 0) begin
                  check("rvalid_unexp", 32'(rvalid), 32'd0);
               end else begin
                  r = rdq[i].pop_front();
                  check("rdata", rdata, r.d);
                  check("rd_latency", 32'(cyc), 32'(r.due));
               end
            end
         end
         if (g != '0) begin
            check("gnt_onehot", 32'($onehot(g)), 32'd1);
            idx = 0;
            for (int i = 0; i < NREQ; i++) if (g[i]) idx = i;
            obs_cyc.push_back(cyc);
            if (!auto_drv || exp_gnt.size() == 0 || cmdq[idx].size() == 0) begin
               check("gnt_unexp", 32'(g), 32'd0);
            end else begin
               check("gnt_order", 32'(idx), 32'(exp_gnt.pop_front()));
               c = cmdq[idx].pop_front();
               check("gnt_wait", 32'((cyc - first_sample[idx] + 1) <= 3), 32'd1);
               check("acc_ena", {31'b0, ram_ena}, 32'd1);
               check("acc_wena", {31'b0, ram_wena}, {31'b0, c.we});
               check("acc_addr", 32'(ram_addr), 32'(c.a));
               if (c.we) begin
                  check("acc_wdata", ram_data, c.d);
                  shadow[c.a] = c.d;
               end else begin
                  r.d   = shadow[c.a];
                  r.due = cyc + 1;
                  rdq[idx].push_back(r);
               end
            end
         end
         if (auto_drv) begin
            for (int i = 0; i < NREQ; i++) begin
               if (cmdq[i].size() > 0) begin
                  if (!req[i] || g[i]) first_sample[i] = cyc + (ram_ena ? 2 : 1);
                  c = cmdq[i][0];
                  req[i]              = 1'b1;
                  we[i]               = c.we;
                  addr[i*AW +: AW]    = c.a;
                  wdata[i*DW +: DW]   = c.d;
               end else begin
                  req[i] = 1'b0;
               end
            end
         end
      end
      prev_ena = ram_ena;
   endtask

   task automatic tick();
      @(negedge clk);
      monitor_step();
   endtask

   task automatic drain(input string tag);
      bit done;
      done = 1'b0;
      for (int n = 0; n < 200; n++) begin
         tick();
         if (cmdq[0].size() == 0 && cmdq[1].size() == 0 && rdq[0].size() == 0 &&
             rdq[1].size() == 0 && exp_gnt.size() == 0 && !ram_ena) begin
            done = 1'b1;
            break;
         end
      end
      check({tag, "_drain"}, 32'(done), 32'd1);
   endtask

   initial begin
      for (int i = 0; i < 32; i++) shadow[i] = 32'h1000_0000 + 32'(i);

      // Reset state
      repeat (3) tick();
      check("rst_gnt", 32'(gnt), 32'd0);
      check("rst_rvalid", 32'(rvalid), 32'd0);
      check("rst_rdata", rdata, 32'd0);
      check("rst_ena", {31'b0, ram_ena}, 32'd0);
      check("rst_wena", {31'b0, ram_wena}, 32'd0);
      check("rst_addr", 32'(ram_addr), 32'd0);
      rst_n = 1'b1;
      tick();

      // Write then read-back by requester 0, then a read by requester 1
      exp_gnt.push_back(0); exp_gnt.push_back(0);
      push_cmd(0, 1'b1, 5'h00, 32'h1234_5678);
      push_cmd(0, 1'b0, 5'h00, 32'hBAD0_0000);
      drain("t1a");
      exp_gnt.push_back(1);
      push_cmd(1, 1'b0, 5'h00, 32'hBAD1_0000);
      drain("t1b");

      // Simultaneous writes from both, then read-backs
      obs_cyc.delete();
      exp_gnt.push_back(0); exp_gnt.push_back(1); exp_gnt.push_back(0); exp_gnt.push_back(1);
      push_cmd(0, 1'b1, 5'h01, 32'hA5A5_A5A5);
      push_cmd(0, 1'b0, 5'h01, 32'hBAD0_0001);
      push_cmd(1, 1'b1, 5'h1B, 32'h7777_7777);
      push_cmd(1, 1'b0, 5'h1B, 32'hBAD1_001B);
      drain("t2");
      check("t2_ngnt", 32'(obs_cyc.size()), 32'd4);
      if (obs_cyc.size() >= 2) check("t2_gap", 32'(obs_cyc[1] - obs_cyc[0]), 32'd2);

      // Continuous reads from both with the pointer at 1
      exp_gnt.push_back(0);
      push_cmd(0, 1'b0, 5'h00, 32'hBAD0_0000);
      drain("t3a");
      exp_gnt.push_back(1); exp_gnt.push_back(0); exp_gnt.push_back(1); exp_gnt.push_back(0);
      push_cmd(0, 1'b0, 5'h01, 32'hFFFF_0001);
      push_cmd(0, 1'b0, 5'h1B, 32'hFFFF_001B);
      push_cmd(1, 1'b0, 5'h00, 32'hEEEE_0000);
      push_cmd(1, 1'b0, 5'h01, 32'hEEEE_0001);
      drain("t3");

      // Write by 1 immediately followed by a read of the same word by 0
      exp_gnt.push_back(1); exp_gnt.push_back(0);
      push_cmd(1, 1'b1, 5'h1B, 32'hCAFE_F00D);
      push_cmd(0, 1'b0, 5'h1B, 32'h5555_AAAA);
      drain("t4");
      check("t4_mem", mem[27], 32'hCAFE_F00D);

      // Request withdrawn before it is sampled
      auto_drv = 1'b0;
      @(posedge clk);
      #1;
      req[0]          = 1'b1;
      we[0]           = 1'b0;
      addr[0 +: AW]   = 5'h03;
      tick();
      req[0] = 1'b0;
      for (int n = 0; n < 3; n++) begin
         tick();
         check("wd_ena", {31'b0, ram_ena}, 32'd0);
         check("wd_gnt", 32'(gnt), 32'd0);
      end
      auto_drv = 1'b1;
      exp_gnt.push_back(1); exp_gnt.push_back(0);
      push_cmd(0, 1'b0, 5'h1B, 32'h0F0F_0F0F);
      push_cmd(1, 1'b0, 5'h05, 32'hF0F0_F0F0);
      drain("t6");

      // Reset asserted in the middle of a write access
      auto_drv = 1'b0;
      tick();
      req[0]          = 1'b1;
      we[0]           = 1'b1;
      addr[0 +: AW]   = 5'h05;
      wdata[0 +: DW]  = 32'hDEAD_BEEF;
      @(posedge clk);
      #1;
      check("ra_ena", {31'b0, ram_ena}, 32'd1);
      check("ra_gnt", 32'(gnt), 32'd1);
      check("ra_data", ram_data, 32'hDEAD_BEEF);
      req = '0;
      we  = '0;
      #1;
      rst_n = 1'b0;
      #1;
      check("ra_rst_ena", {31'b0, ram_ena}, 32'd0);
      check("ra_rst_wena", {31'b0, ram_wena}, 32'd0);
      check("ra_rst_gnt", 32'(gnt), 32'd0);
      check("ra_rst_rvalid", 32'(rvalid), 32'd0);
      tick();
      tick();
      rst_n = 1'b1;
      for (int n = 0; n < 4; n++) begin
         tick();
         check("ra_post_gnt", 32'(gnt), 32'd0);
         check("ra_post_rvalid", 32'(rvalid), 32'd0);
         check("ra_post_ena", {31'b0, ram_ena}, 32'd0);
      end
      check("ra_mem05", mem[5], 32'h1000_0005);
      check("ra_rdata", rdata, 32'd0);
      auto_drv = 1'b1;
      exp_gnt.push_back(0); exp_gnt.push_back(1);
      push_cmd(0, 1'b0, 5'h05, 32'h1111_0000);
      push_cmd(1, 1'b0, 5'h05, 32'h2222_0000);
      drain("t5");

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
